// File: rtl/memory_bank_arbiter_pkg.sv
// Shared definitions for the memory bank arbiter: default geometry,
// grant index width and the two-state FSM encoding.
package mem_arb_pkg;

  localparam int NREQ_DEF      = 4;
  localparam int ADDR_BITS_DEF = 15;
  localparam int DATA_BITS_DEF = 16;
  localparam int GRANT_ID_BITS = 3;

  // FSM encoding kept as plain constants so older tools read it unchanged
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  typedef logic [GRANT_ID_BITS-1:0] grant_id_t;

endpackage

// File: rtl/memory_bank_arbiter_if.sv
// Bundle of the per-master request ports and the bank RAM ports.
// The arbiter sits on the slave side; masters and the RAM drive the
// master side.
interface memory_bank_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int NREQ      = NREQ_DEF,
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF
) ();

  logic [NREQ-1:0]           req_valid;
  logic [NREQ*ADDR_BITS-1:0] req_addr;
  logic [NREQ*DATA_BITS-1:0] req_wdata;
  logic [NREQ-1:0]           req_wr;
  logic [NREQ*2-1:0]         req_wr_mask;
  logic [NREQ-1:0]           req_rdy;
  logic [DATA_BITS-1:0]      rdata;

  logic [ADDR_BITS-1:0]      bank_addr;
  logic [DATA_BITS-1:0]      bank_wdata;
  logic                      bank_wr;
  logic [1:0]                bank_wr_mask;
  logic [DATA_BITS-1:0]      bank_rdata;

  modport slave (
    input  req_valid, req_addr, req_wdata, req_wr, req_wr_mask, bank_rdata,
    output req_rdy, rdata, bank_addr, bank_wdata, bank_wr, bank_wr_mask
  );

  modport master (
    output req_valid, req_addr, req_wdata, req_wr, req_wr_mask, bank_rdata,
    input  req_rdy, rdata, bank_addr, bank_wdata, bank_wr, bank_wr_mask
  );

endinterface

// File: rtl/memory_bank_arbiter_rr_pick.sv
// Round-robin winner selection: scans upward from the master after the
// last owner, wrapping modulo NREQ, and reports the first active request.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0] req,
  input  grant_id_t       last_owner,
  output logic            any_req,
  output grant_id_t       winner
);

  logic [7:0] req_ext;
  logic [3:0] cand;
  logic       found;

  // Wrap is done by subtracting NREQ so non power-of-two counts rotate correctly
  always_comb begin
    req_ext = 8'(req);
    any_req = |req;
    winner  = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, last_owner} + 4'(k);
      if (cand >= 4'(NREQ)) begin
        cand = cand - 4'(NREQ);
      end
      if (!found && req_ext[cand[2:0]]) begin
        found  = 1'b1;
        winner = cand[2:0];
      end
    end
  end

endmodule

// File: rtl/memory_bank_arbiter.sv
// Round-robin owner of a single synchronous memory bank. A master keeps
// the bank for as long as it holds valid; every hand-over passes through
// one IDLE cycle for bank turnaround.
module memory_bank_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ      = NREQ_DEF,
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  memory_bank_arbiter_if.slave  bus,
  output grant_id_t             grant_id,
  output logic                  busy
);

  logic [0:0]           state_q, state_d;
  logic [NREQ-1:0]      req_rdy_q, req_rdy_d;
  grant_id_t            grant_id_q, grant_id_d;
  grant_id_t            last_owner_q, last_owner_d;

  logic                 any_req;
  grant_id_t            winner;

  logic                 owner_valid;
  logic                 owner_wr;
  logic [ADDR_BITS-1:0] owner_addr;
  logic [DATA_BITS-1:0] owner_wdata;
  logic [1:0]           owner_mask;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req        (bus.req_valid),
    .last_owner (last_owner_q),
    .any_req    (any_req),
    .winner     (winner)
  );

  // Select the current owner's request fields from the packed buses
  always_comb begin
    owner_valid = 1'b0;
    owner_wr    = 1'b0;
    owner_addr  = '0;
    owner_wdata = '0;
    owner_mask  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id_q == GRANT_ID_BITS'(i)) begin
        owner_valid = bus.req_valid[i];
        owner_wr    = bus.req_wr[i];
        owner_addr  = bus.req_addr[i*ADDR_BITS +: ADDR_BITS];
        owner_wdata = bus.req_wdata[i*DATA_BITS +: DATA_BITS];
        owner_mask  = bus.req_wr_mask[i*2 +: 2];
      end
    end
  end

  // Grant from IDLE only, release when the owner drops valid; no preemption
  always_comb begin
    state_d      = state_q;
    req_rdy_d    = req_rdy_q;
    grant_id_d   = grant_id_q;
    last_owner_d = last_owner_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d      = ST_GRANT;
          grant_id_d   = winner;
          last_owner_d = winner;
          for (int i = 0; i < NREQ; i++) begin
            req_rdy_d[i] = (winner == GRANT_ID_BITS'(i));
          end
        end
      end
      default: begin
        if (!owner_valid) begin
          state_d   = ST_IDLE;
          req_rdy_d = '0;
        end
      end
    endcase
  end

  // State and grant registers; last owner resets to NREQ-1 so master 0 wins first
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      req_rdy_q    <= '0;
      grant_id_q   <= '0;
      last_owner_q <= GRANT_ID_BITS'(NREQ - 1);
    end else begin
      state_q      <= state_d;
      req_rdy_q    <= req_rdy_d;
      grant_id_q   <= grant_id_d;
      last_owner_q <= last_owner_d;
    end
  end

  // Bank port is quiet in IDLE and follows the owner combinationally in GRANT
  always_comb begin
    bus.bank_addr    = '0;
    bus.bank_wdata   = '0;
    bus.bank_wr_mask = '0;
    bus.bank_wr      = 1'b0;
    if (state_q == ST_GRANT) begin
      bus.bank_addr    = owner_addr;
      bus.bank_wdata   = owner_wdata;
      bus.bank_wr_mask = owner_mask;
      bus.bank_wr      = owner_wr & owner_valid;
    end
  end

  assign bus.req_rdy = req_rdy_q;
  assign bus.rdata   = bus.bank_rdata;
  assign grant_id    = grant_id_q;
  assign busy        = (state_q == ST_GRANT);

endmodule

// File: tb/tb_memory_bank_arbiter.sv
// Bench for memory_bank_arbiter with a behavioural bank RAM, a grant
// scoreboard and a read-data scoreboard.
module tb_memory_bank_arbiter;

  localparam int NREQ = 4;
  localparam int AB   = 15;
  localparam int DB   = 16;

  typedef struct {
    int id;
    int gap;
  } grant_exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] grant_id;
  logic       busy;

  int check_count = 0;
  int error_count = 0;

  grant_exp_t  grant_q[$];
  logic [15:0] rd_q[$];
  bit          rd_issue   = 1'b0;
  bit          rd_pending = 1'b0;
  bit          busy_prev  = 1'b0;
  int          idle_run   = 0;

  logic [15:0] mem [0:32767];

  memory_bank_arbiter_if #(.NREQ(NREQ), .ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

  memory_bank_arbiter #(.NREQ(NREQ), .ADDR_BITS(AB), .DATA_BITS(DB)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .grant_id (grant_id),
    .busy     (busy)
  );

  // Free-running clock
  always #5 clk = ~clk;

  function automatic logic [15:0] pat(input logic [14:0] a);
    return {1'b0, a} ^ 16'h5A3C;
  endfunction

  // Synchronous bank RAM: byte-masked write, registered read
  always @(posedge clk) begin
    if (bus.bank_wr) begin
      if (bus.bank_wr_mask[1]) mem[bus.bank_addr][15:8] <= bus.bank_wdata[15:8];
      if (bus.bank_wr_mask[0]) mem[bus.bank_addr][7:0]  <= bus.bank_wdata[7:0];
    end
    bus.bank_rdata <= mem[bus.bank_addr];
  end

  task automatic check_output(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Scoreboard monitor: new grants and read data, sampled on the falling edge
  always @(negedge clk) begin
    grant_exp_t ge;
    logic [15:0] exp_rd;
    if (busy && !busy_prev) begin
      if (grant_q.size() == 0) begin
        check_output("unexpected_grant", 32'(grant_id), 32'hFFFF_FFFF);
      end else begin
        ge = grant_q.pop_front();
        check_output("grant_id", 32'(grant_id), 32'(ge.id));
        check_output("grant_rdy", 32'(bus.req_rdy), 32'(1) << ge.id);
        if (ge.gap >= 0) check_output("idle_gap", 32'(idle_run), 32'(ge.gap));
      end
    end
    if (busy) idle_run = 0;
    else idle_run++;
    busy_prev = busy;
    if (rd_pending) begin
      if (rd_q.size() == 0) begin
        check_output("rd_q_empty", 32'(bus.rdata), 32'hFFFF_FFFF);
      end else begin
        exp_rd = rd_q.pop_front();
        check_output("rdata", 32'(bus.rdata), 32'(exp_rd));
      end
    end
    rd_pending = rd_issue;
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    rd_issue = 1'b0;
  endtask

  task automatic apply_stimulus(input int m, input logic v, input logic w,
                                input logic [14:0] a, input logic [15:0] d,
                                input logic [1:0] mk);
    bus.req_valid[m]          = v;
    bus.req_wr[m]             = w;
    bus.req_addr[m*AB +: AB]  = a;
    bus.req_wdata[m*DB +: DB] = d;
    bus.req_wr_mask[m*2 +: 2] = mk;
  endtask

  task automatic do_read(input int m, input logic [14:0] a, input logic [15:0] exp_d);
    apply_stimulus(m, 1'b1, 1'b0, a, 16'h0, 2'b00);
    rd_issue = 1'b1;
    rd_q.push_back(exp_d);
  endtask

  task automatic push_grant(input int id, input int gap);
    grant_exp_t ge;
    ge.id  = id;
    ge.gap = gap;
    grant_q.push_back(ge);
  endtask

  task automatic wait_rdy(input int m, output int n);
    bit seen;
    seen = 1'b0;
    n    = -1;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (bus.req_rdy[m]) begin
        seen = 1'b1;
        n    = i;
        break;
      end
    end
    if (!seen) check_output("rdy_timeout", 32'(bus.req_rdy[m]), 32'd1);
  endtask

  task automatic pulse_reset();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  // Bound the whole run in case the DUT never grants
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios
  initial begin
    int n;
    for (int i = 0; i < 32768; i++) mem[i] = pat(15'(i));
    rst             = 1'b1;
    bus.req_valid   = '0;
    bus.req_wr      = '0;
    bus.req_addr    = '0;
    bus.req_wdata   = '0;
    bus.req_wr_mask = '0;
    repeat (3) cycle();
    @(negedge clk);
    check_output("rst_rdy", 32'(bus.req_rdy), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_grant_id", 32'(grant_id), 32'd0);
    check_output("rst_bank_wr", 32'(bus.bank_wr), 32'd0);
    check_output("rst_bank_addr", 32'(bus.bank_addr), 32'd0);
    check_output("rst_bank_wdata", 32'(bus.bank_wdata), 32'd0);
    check_output("rst_bank_mask", 32'(bus.bank_wr_mask), 32'd0);
    cycle();
    rst = 1'b0;

    $display("[TB] single master 2 read burst");
    push_grant(2, -1);
    apply_stimulus(2, 1'b1, 1'b0, 15'h0010, 16'h0, 2'b00);
    wait_rdy(2, n);
    check_output("m2_latency", 32'(n), 32'd1);
    do_read(2, 15'h0010, pat(15'h0010));
    for (int a = 16'h11; a <= 16'h13; a++) begin
      cycle();
      do_read(2, 15'(a), pat(15'(a)));
    end
    cycle();
    do_read(2, 15'h0013, pat(15'h0013));
    cycle();
    apply_stimulus(2, 1'b0, 1'b0, 15'h0, 16'h0, 2'b00);
    repeat (2) cycle();

    $display("[TB] masters 0 and 1 together after reset");
    pulse_reset();
    push_grant(0, -1);
    push_grant(1, 1);
    apply_stimulus(0, 1'b1, 1'b0, 15'h0100, 16'h0, 2'b00);
    apply_stimulus(1, 1'b1, 1'b0, 15'h0200, 16'h0, 2'b00);
    wait_rdy(0, n);
    check_output("m0_first_latency", 32'(n), 32'd1);
    cycle();
    cycle();
    apply_stimulus(0, 1'b0, 1'b0, 15'h0, 16'h0, 2'b00);
    wait_rdy(1, n);
    check_output("m1_after_release", 32'(n), 32'd2);
    cycle();
    apply_stimulus(1, 1'b0, 1'b0, 15'h0, 16'h0, 2'b00);
    repeat (2) cycle();

    $display("[TB] all masters rotating");
    pulse_reset();
    push_grant(0, -1);
    for (int g = 1; g < 6; g++) push_grant(g % NREQ, 1);
    for (int m = 0; m < NREQ; m++) apply_stimulus(m, 1'b1, 1'b0, 15'(m), 16'h0, 2'b00);
    for (int g = 0; g < 6; g++) begin
      wait_rdy(g % NREQ, n);
      check_output("rotate_latency", 32'(n), 32'd1);
      cycle();
      cycle();
      cycle();
      if (g == 5) begin
        for (int m = 0; m < NREQ; m++) apply_stimulus(m, 1'b0, 1'b0, 15'h0, 16'h0, 2'b00);
      end else begin
        apply_stimulus(g % NREQ, 1'b0, 1'b0, 15'(g % NREQ), 16'h0, 2'b00);
        cycle();
        apply_stimulus(g % NREQ, 1'b1, 1'b0, 15'(g % NREQ), 16'h0, 2'b00);
      end
    end
    repeat (3) cycle();

    $display("[TB] master 3 masked write and read back");
    push_grant(3, -1);
    apply_stimulus(3, 1'b1, 1'b1, 15'h4000, 16'hBEEF, 2'b10);
    @(negedge clk);
    check_output("wr_in_idle", 32'(bus.bank_wr), 32'd0);
    wait_rdy(3, n);
    check_output("m3_latency", 32'(n), 32'd1);
    @(negedge clk);
    check_output("wr_grant", 32'(bus.bank_wr), 32'd1);
    check_output("wr_addr", 32'(bus.bank_addr), 32'h4000);
    check_output("wr_wdata", 32'(bus.bank_wdata), 32'hBEEF);
    check_output("wr_mask", 32'(bus.bank_wr_mask), 32'h2);
    cycle();
    do_read(3, 15'h4000, 16'hBE3C);
    cycle();
    apply_stimulus(3, 1'b0, 1'b1, 15'h4000, 16'hBEEF, 2'b10);
    @(negedge clk);
    check_output("wr_gated_release", 32'(bus.bank_wr), 32'd0);
    cycle();
    apply_stimulus(3, 1'b0, 1'b0, 15'h0, 16'h0, 2'b00);
    repeat (2) cycle();

    $display("[TB] no preemption of master 1 by master 0");
    push_grant(1, -1);
    push_grant(0, 1);
    apply_stimulus(1, 1'b1, 1'b0, 15'h0020, 16'h0, 2'b00);
    wait_rdy(1, n);
    check_output("m1_latency", 32'(n), 32'd1);
    cycle();
    apply_stimulus(0, 1'b1, 1'b0, 15'h0030, 16'h0, 2'b00);
    for (int i = 0; i < 3; i++) begin
      cycle();
      @(negedge clk);
      check_output("no_preempt_rdy", 32'(bus.req_rdy), 32'h2);
    end
    cycle();
    apply_stimulus(1, 1'b0, 1'b0, 15'h0, 16'h0, 2'b00);
    wait_rdy(0, n);
    check_output("m0_after_m1", 32'(n), 32'd2);
    cycle();
    apply_stimulus(0, 1'b0, 1'b0, 15'h0, 16'h0, 2'b00);
    repeat (2) cycle();

    $display("[TB] reset during master 2 write burst");
    push_grant(2, -1);
    apply_stimulus(2, 1'b1, 1'b1, 15'h0100, 16'h1234, 2'b11);
    wait_rdy(2, n);
    check_output("m2_wr_latency", 32'(n), 32'd1);
    cycle();
    rst = 1'b1;
    apply_stimulus(2, 1'b1, 1'b1, 15'h0101, 16'h5678, 2'b11);
    @(negedge clk);
    check_output("wr_in_rst_cycle", 32'(bus.bank_wr), 32'd1);
    cycle();
    rst = 1'b0;
    apply_stimulus(2, 1'b1, 1'b0, 15'h0101, 16'h0, 2'b00);
    push_grant(0, 1);
    apply_stimulus(0, 1'b1, 1'b0, 15'h0100, 16'h0, 2'b00);
    @(negedge clk);
    check_output("post_rst_rdy", 32'(bus.req_rdy), 32'd0);
    check_output("post_rst_busy", 32'(busy), 32'd0);
    check_output("post_rst_bank_wr", 32'(bus.bank_wr), 32'd0);
    wait_rdy(0, n);
    check_output("m0_post_rst", 32'(n), 32'd1);
    do_read(0, 15'h0100, 16'h1234);
    cycle();
    do_read(0, 15'h0101, 16'h5678);
    cycle();
    apply_stimulus(0, 1'b0, 1'b0, 15'h0, 16'h0, 2'b00);
    apply_stimulus(2, 1'b0, 1'b0, 15'h0, 16'h0, 2'b00);
    repeat (3) cycle();

    check_output("grants_left", 32'(grant_q.size()), 32'd0);
    check_output("reads_left", 32'(rd_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
